// File: rtl/sdram_port_arbiter_if.sv
// Burst memory port: requester drives req/wren/address/to_mem, memory side returns ready/offset.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int BURST  = 4
);
  localparam int OFF_W = $clog2(BURST);

  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] to_mem;
  logic              ready;
  logic [OFF_W-1:0]  offset;

  modport master (output req, wren, address, to_mem, input ready, offset);
  modport slave  (input req, wren, address, to_mem, output ready, offset);
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller burst port between three requesters, one full burst per grant.
//   state   | meaning
//   IDLE    | no owner; pick a winner among pending requests
//   BUSY    | owner's burst in flight; m_req high, beats routed to owner
//   RELEASE | final beat taken; m_req low, grant held for one cycle
module sdram_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int BURST  = 4,
  parameter int RR     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  sdram_port_arbiter_if.slave          p0,
  sdram_port_arbiter_if.slave          p1,
  sdram_port_arbiter_if.slave          p2,
  sdram_port_arbiter_if.master         m,
  output logic [2:0]                   grant,
  output logic                         busy
);
  localparam int OFF_W = $clog2(BURST);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic              m_req_q, m_req_d;
  logic              busy_q, busy_d;
  logic [2:0]        req_v, win_oh, cand;
  logic [1:0]        win_idx, start_idx;
  logic              beat_ok, wren_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;

  assign req_v = {p2.req, p1.req, p0.req};

  // Scan the three candidates from the highest index down so the first in search order wins.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    cand      = '0;
    start_idx = 2'd0;
    if (RR != 0) start_idx = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, start_idx} + 3'(k);
      if (cand > 3'd2) cand = cand - 3'd3;
      if (req_v[cand[1:0]]) begin
        win_oh  = 3'b001 << cand;
        win_idx = cand[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd2;
      m_req_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      m_req_q <= m_req_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req_v) begin
          state_d = BUSY;
          grant_d = win_oh;
          last_d  = win_idx;
        end
      end
      BUSY:    if (m.ready && m.offset == LAST_OFF) state_d = RELEASE;
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    m_req_d = (state_d == BUSY);
    busy_d  = (state_d != IDLE);
  end

  // Beats are only forwarded while BUSY; stray strobes in IDLE/RELEASE never reach a requester.
  always_comb begin
    beat_ok   = (state_q == BUSY);
    wren_mux  = 1'b0;
    addr_mux  = '0;
    data_mux  = '0;
    p0.ready  = 1'b0;
    p0.offset = '0;
    p1.ready  = 1'b0;
    p1.offset = '0;
    p2.ready  = 1'b0;
    p2.offset = '0;
    if (grant_q[0]) begin
      wren_mux  = p0.wren;
      addr_mux  = p0.address;
      data_mux  = p0.to_mem;
      p0.ready  = m.ready & beat_ok;
      p0.offset = beat_ok ? m.offset : '0;
    end
    if (grant_q[1]) begin
      wren_mux  = p1.wren;
      addr_mux  = p1.address;
      data_mux  = p1.to_mem;
      p1.ready  = m.ready & beat_ok;
      p1.offset = beat_ok ? m.offset : '0;
    end
    if (grant_q[2]) begin
      wren_mux  = p2.wren;
      addr_mux  = p2.address;
      data_mux  = p2.to_mem;
      p2.ready  = m.ready & beat_ok;
      p2.offset = beat_ok ? m.offset : '0;
    end
  end

  assign m.req     = m_req_q;
  assign m.wren    = wren_mux;
  assign m.address = addr_mux;
  assign m.to_mem  = data_mux;
  assign grant     = grant_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 fixed priority, both fed the same requests.
module tb_sdram_port_arbiter;
  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int BURST = 4;

  typedef struct {
    int          port;
    int          off;
    logic        wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [2:0]    wren_cfg;
  logic [AW-1:0] addr_cfg [3];
  logic [DW-1:0] base_cfg [3];
  logic          stray;

  logic [2:0]    o_ready [2];
  logic [1:0]    o_off   [2][3];
  logic          o_wren  [2];
  logic [AW-1:0] o_addr  [2];
  logic [DW-1:0] o_data  [2];
  logic          o_mreq  [2];
  logic [2:0]    o_grant [2];
  logic          o_busy  [2];

  int    total = 0;
  int    bad   = 0;
  beat_t q_exp0[$];
  beat_t q_exp1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) a0 ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) a1 ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) a2 ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) mi ();
    logic       c_ready, c_wait;
    logic [1:0] c_off;
    int         c_cnt;

    assign a0.req = req[0];
    assign a0.wren = wren_cfg[0];
    assign a0.address = addr_cfg[0];
    assign a0.to_mem = base_cfg[0] + DW'(a0.offset);
    assign a1.req = req[1];
    assign a1.wren = wren_cfg[1];
    assign a1.address = addr_cfg[1];
    assign a1.to_mem = base_cfg[1] + DW'(a1.offset);
    assign a2.req = req[2];
    assign a2.wren = wren_cfg[2];
    assign a2.address = addr_cfg[2];
    assign a2.to_mem = base_cfg[2] + DW'(a2.offset);
    assign mi.ready = c_ready;
    assign mi.offset = c_off;
    assign o_ready[g] = {a2.ready, a1.ready, a0.ready};
    assign o_off[g][0] = a0.offset;
    assign o_off[g][1] = a1.offset;
    assign o_off[g][2] = a2.offset;
    assign o_mreq[g] = mi.req;
    assign o_wren[g] = mi.wren;
    assign o_addr[g] = mi.address;
    assign o_data[g] = mi.to_mem;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST), .RR(g == 0 ? 1 : 0)) dut (
      .clk(clk), .rst(rst), .p0(a0), .p1(a1), .p2(a2), .m(mi),
      .grant(o_grant[g]), .busy(o_busy[g]));

    // Controller model: one idle cycle after m_req rises, then BURST consecutive beats.
    initial begin
      c_ready = 1'b0; c_off = '0; c_cnt = 0; c_wait = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          c_ready = 1'b0; c_off = '0; c_cnt = 0; c_wait = 1'b0;
        end else if (stray) begin
          c_ready = 1'b1; c_off = 2'd3;
        end else if (mi.req) begin
          if (!c_wait) begin
            c_wait = 1'b1; c_ready = 1'b0;
          end else if (c_cnt < BURST) begin
            c_ready = 1'b1; c_off = 2'(c_cnt); c_cnt++;
          end else c_ready = 1'b0;
        end else begin
          c_ready = 1'b0; c_off = '0; c_cnt = 0; c_wait = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input int g, input int p);
    beat_t e;
    for (int o = 0; o < BURST; o++) begin
      e.port = p; e.off = o; e.wren = wren_cfg[p]; e.addr = addr_cfg[p];
      e.data = base_cfg[p] + DW'(o);
      if (g == 0) q_exp0.push_back(e); else q_exp1.push_back(e);
    end
  endtask

  task automatic push_seq(input int g, input int p_a, input int p_b, input int p_c, input int p_d);
    push_burst(g, p_a); push_burst(g, p_b); push_burst(g, p_c); push_burst(g, p_d);
  endtask

  task automatic mon_dut(input int g);
    int    port, nset;
    beat_t e;
    logic  ok;
    nset = 0; port = 0;
    for (int n = 0; n < 3; n++) if (o_ready[g][n]) begin nset++; port = n; end
    if (nset == 0) return;
    total++;
    if ((g == 0 && q_exp0.size() == 0) || (g == 1 && q_exp1.size() == 0)) begin
      bad++;
      $display("FAIL beat dut%0d: got pN_ready=%b offset=%0d, required no beat", g, o_ready[g], o_off[g][port]);
      return;
    end
    if (g == 0) e = q_exp0.pop_front(); else e = q_exp1.pop_front();
    ok = (nset == 1) && (port == e.port) && (o_off[g][port] == 2'(e.off)) && (o_wren[g] == e.wren)
         && (o_addr[g] == e.addr) && (o_data[g] == e.data) && (o_grant[g] == (3'b001 << e.port));
    for (int n = 0; n < 3; n++) if (n != port && o_off[g][n] != 2'd0) ok = 1'b0;
    if (!ok) begin
      bad++;
      $display("FAIL beat dut%0d: got ready=%b off=%0d wren=%b addr=%h data=%h grant=%b, required port%0d off=%0d wren=%b addr=%h data=%h",
               g, o_ready[g], o_off[g][port], o_wren[g], o_addr[g], o_data[g], o_grant[g],
               e.port, e.off, e.wren, e.addr, e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk); #2;
      mon_dut(0);
      mon_dut(1);
    end
  end

  task automatic wait_left(input string name, input int left);
    int n = 0;
    while (!(q_exp0.size() <= left && q_exp1.size() <= left) && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL %s: timeout, queues %0d/%0d, required <=%0d", name, q_exp0.size(), q_exp1.size(), left);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_exp0.size() != 0 || q_exp1.size() != 0 || o_busy[0] || o_busy[1]) && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL %s: timeout draining, queues %0d/%0d busy %b/%b, required empty and idle",
               name, q_exp0.size(), q_exp1.size(), o_busy[0], o_busy[1]);
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s idle grant dut%0d", name, g), 32'(o_grant[g]), 32'h0);
      check($sformatf("%s idle m_req dut%0d", name, g), 32'(o_mreq[g]), 32'h0);
    end
  endtask

  initial begin
    req = '0; stray = 1'b0; wren_cfg = 3'b100;
    addr_cfg[0] = 24'h3FF000; addr_cfg[1] = 24'h001234; addr_cfg[2] = 24'h00ABC0;
    base_cfg[0] = 16'h0500;   base_cfg[1] = 16'h1100;   base_cfg[2] = 16'hA000;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset grant dut%0d", g), 32'(o_grant[g]), 32'h0);
      check($sformatf("reset m_req dut%0d", g), 32'(o_mreq[g]), 32'h0);
      check($sformatf("reset busy dut%0d", g), 32'(o_busy[g]), 32'h0);
    end
    @(negedge clk); rst = 1'b1;

    // single read from p1
    @(negedge clk); req = 3'b010; push_burst(0, 1); push_burst(1, 1);
    #2;
    for (int g = 0; g < 2; g++) check($sformatf("read m_req before edge dut%0d", g), 32'(o_mreq[g]), 32'h0);
    @(negedge clk); #2;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("read m_req dut%0d", g), 32'(o_mreq[g]), 32'h1);
      check($sformatf("read m_address dut%0d", g), 32'(o_addr[g]), 32'h001234);
      check($sformatf("read grant dut%0d", g), 32'(o_grant[g]), 32'h2);
      check($sformatf("read busy dut%0d", g), 32'(o_busy[g]), 32'h1);
      check($sformatf("read m_wren dut%0d", g), 32'(o_wren[g]), 32'h0);
    end
    wait_left("read", 1);
    @(negedge clk); req = 3'b000;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("release m_req dut%0d", g), 32'(o_mreq[g]), 32'h0);
      check($sformatf("release grant dut%0d", g), 32'(o_grant[g]), 32'h2);
      check($sformatf("release busy dut%0d", g), 32'(o_busy[g]), 32'h1);
    end
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("post-release grant dut%0d", g), 32'(o_grant[g]), 32'h0);
      check($sformatf("post-release busy dut%0d", g), 32'(o_busy[g]), 32'h0);
    end
    wait_drain("read");

    // write burst from p2
    @(negedge clk); req = 3'b100; push_burst(0, 2); push_burst(1, 2);
    wait_left("write", 1);
    @(negedge clk); req = 3'b000;
    wait_drain("write");

    // all three requesting: RR rotates from p0, fixed priority keeps p0
    @(negedge clk); req = 3'b111; push_seq(0, 0, 1, 2, 0); push_seq(1, 0, 0, 0, 0);
    wait_left("all3", 1);
    @(negedge clk); req = 3'b000;
    wait_drain("all3");

    // p0 and p2: fixed priority starves p2 until p0 drops
    @(negedge clk); req = 3'b101; push_seq(0, 2, 0, 2, 2); push_seq(1, 0, 0, 0, 2);
    wait_left("p0p2", BURST + 1);
    @(negedge clk); req = 3'b100;
    wait_left("p2 alone", 1);
    @(negedge clk); req = 3'b000;
    wait_drain("p0p2");

    // owner drops req after beat 1; remaining beats still forwarded
    @(negedge clk); req = 3'b001; push_burst(0, 0); push_burst(1, 0);
    wait_left("violation", 2);
    req = 3'b000;
    wait_drain("violation");
    @(negedge clk); stray = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      for (int g = 0; g < 2; g++) check($sformatf("stray ready dut%0d", g), 32'(o_ready[g]), 32'h0);
    end
    stray = 1'b0;
    @(negedge clk); #2;
    for (int g = 0; g < 2; g++) check($sformatf("stray busy dut%0d", g), 32'(o_busy[g]), 32'h0);

    // async reset in the middle of a p2 burst
    @(negedge clk); req = 3'b100; push_burst(0, 2); push_burst(1, 2);
    wait_left("midreset", 2);
    #1 rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("midreset grant dut%0d", g), 32'(o_grant[g]), 32'h0);
      check($sformatf("midreset m_req dut%0d", g), 32'(o_mreq[g]), 32'h0);
      check($sformatf("midreset busy dut%0d", g), 32'(o_busy[g]), 32'h0);
    end
    q_exp0.delete(); q_exp1.delete();
    req = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); req = 3'b011; push_burst(0, 0); push_burst(1, 0);
    wait_left("after reset", 1);
    @(negedge clk); req = 3'b000;
    wait_drain("after reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Three-way arbiter that shares one burst port of the SDRAM controller between three cache/DMA requesters (program cache, data cache, display fetch). It sits between the requesters' mem_* interfaces and a single controller port: it grants one requester at a time for a full 4-word burst, muxes address/wren/write data down, and routes ready/offset back to the owner only. Fixed-priority or round-robin selection is chosen by parameter.

## Interface
- ADDR_W, 24, word address width of every port
- DATA_W, 16, data width
- BURST, 4, words per transaction; offset width is $clog2(BURST)
- RR, 1, 1 = round-robin, 0 = fixed priority p0 > p1 > p2

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-low
- pN_req  in  1  requester N (N = 0,1,2) burst request, held until its last beat
- pN_wren  in  1  requester N write (1) / read (0), stable while pN_req high
- pN_address  in  ADDR_W  requester N burst base address, stable while pN_req high
- pN_to_mem  in  DATA_W  requester N write data for the offset currently on pN_offset
- pN_ready  out  1  beat strobe to requester N
- pN_offset  out  log2(BURST)  beat index to requester N
- m_req  out  1  request to controller port
- m_wren  out  1  write select to controller
- m_address  out  ADDR_W  address to controller
- m_to_mem  out  DATA_W  write data to controller
- m_ready  in  1  controller beat strobe
- m_offset  in  log2(BURST)  controller beat index
- grant  out  3  one-hot current owner, 0 when none
- busy  out  1  high in BUSY and RELEASE

## Operation
- States: IDLE, BUSY, RELEASE. Reset: IDLE, grant = 0, m_req = 0, last-owner pointer = 2 (so p0 wins first under RR).
- IDLE: if any pN_req high, select winner, load grant, go BUSY. No request: stay.
- Fixed priority: lowest N wins. Round-robin: search order starts at (last+1) mod 3, wraps; pointer updates to winner on grant.
- BUSY: m_req = 1. m_wren, m_address, m_to_mem driven from granted port. pN_ready = m_ready & grant[N]; pN_offset = m_offset when grant[N], else 0.
- BUSY exit: m_ready high with m_offset == BURST-1 -> RELEASE. Earlier beats do not change state.
- RELEASE: m_req = 0, grant held, one cycle, then IDLE with grant cleared.
- No grant: m_wren = 0, m_address = 0, m_to_mem = 0, all pN_ready = 0.
- Owner dropping pN_req inside BUSY is a protocol violation; arbiter ignores it and holds the grant until the final beat.
- Requests arriving during BUSY/RELEASE wait; no request is lost as requesters hold req.
- m_ready while IDLE/RELEASE: ignored, not forwarded.
- Async reset mid-burst: immediate return to reset values; the controller is reset by the same rst.

## Timing
- m_req, grant, busy are registered; mux paths (address, wren, to_mem, ready, offset) are combinational from grant register.
- Request sampled at edge k -> grant and m_req high after edge k (cycle k+1).
- Last beat sampled at edge t -> m_req low from t; IDLE from t+1; next grant earliest after edge t+1; m_req low for at least 2 cycles between bursts.
- Minimum cycle count per burst: 1 (grant) + BURST beats + 1 (RELEASE) + 1 (IDLE) when back-to-back requests are pending.
- pN_ready / pN_offset have zero latency relative to m_ready / m_offset.

## Test plan
- Reset: rst low mid-BUSY -> grant = 0, m_req = 0, busy = 0 immediately; after release, p0/p1 both requesting -> p0 granted first.
- Single read: p1 req, addr 0x00_1234, wren 0 -> m_address = 0x001234, m_req high one cycle later; 4 m_ready beats offsets 0..3 appear only on p1_ready/p1_offset; m_req low after offset 3.
- Write mux: p2 write burst, p2_to_mem = 0xA000 + p2_offset -> m_to_mem tracks 0xA000..0xA003 as m_offset steps 0..3; m_wren = 1.
- Round-robin (RR=1): p0,p1,p2 hold req continuously -> grant order 001,010,100,001; each separated by RELEASE+IDLE.
- Fixed priority (RR=0): p0 and p2 continuously requesting -> p0 granted every burst, p2 starves; p2 granted once p0 drops req.
- Violation: owner drops req after beat 1 -> grant held, beats 2,3 still forwarded, RELEASE after offset 3; stray m_ready in IDLE -> no pN_ready pulses.
